// File: rtl/cyber_press_pkg.sv
// Shared types and constants for the press-pulse generator.
// Latency: n/a (declarations only).
// Backpressure: n/a; every consumer takes a strobe every cycle.
package cyber_press_pkg;

    localparam int LFSR_W_DEF  = 10;
    localparam int HOLDOFF_DEF = 4;

    // Feedback taps for x^10 + x^7 + 1 (bit indices of the 10-bit register)
    localparam int LFSR_TAP_HI = 9;
    localparam int LFSR_TAP_LO = 6;

    // XNOR feedback makes all-zeros a legal state, so reset can use it
    localparam logic [LFSR_W_DEF-1:0] LFSR_RESET = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        HOLD  = 2'd2
    } cp_state_t;

endpackage

// File: rtl/cyber_press_if.sv
// Bundle between the board keys/switches and the playfield press strobes.
// Latency: n/a (wiring only).
// Backpressure: none; strobes are fire-and-forget single-cycle pulses.
interface cyber_press_if #(
    parameter int LFSR_W = 10
);
    logic              freset;
    logic              enable;
    logic              key_n;
    logic [LFSR_W-1:0] SW;
    logic              human_press;
    logic              cpu_press;
    logic [LFSR_W-1:0] rnd;

    // Board / stimulus side drives the controls and observes the strobes
    modport master (
        output freset, enable, key_n, SW,
        input  human_press, cpu_press, rnd
    );

    // Press generator side
    modport slave (
        input  freset, enable, key_n, SW,
        output human_press, cpu_press, rnd
    );

endinterface

// File: rtl/cyber_press_key_pulse.sv
// Turns a raw asynchronous active-low key into one strobe per press.
// Latency: strobe is high 3 edges after the key is first sampled low.
// Backpressure: none; a held key yields one pulse, release yields none.
module key_pulse (
    input  logic Clock,
    input  logic Reset,
    input  logic freset,
    input  logic enable,
    input  logic key_n,
    output logic press
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;
    logic press_q, press_d;

    // Synchronizer chain and rising-edge detect; prev keeps tracking during
    // freset so a key held across a round reset does not fire when it drops
    always_comb begin
        sync1_d = ~key_n;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        press_d = sync2_q & ~prev_q & enable & ~freset;
    end

    // State registers with synchronous full reset
    always_ff @(posedge Clock) begin
        if (Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/cyber_press.sv
// Human and CPU press-strobe generator for the tug-of-war light chain.
// Latency: CPU strobe 1 cycle after SW>rnd in IDLE; human strobe 3 edges after key.
// Backpressure: none; CPU side self-throttles with a HOLDOFF-cycle quiet period.
module cyber_press
    import cyber_press_pkg::*;
#(
    parameter int LFSR_W  = LFSR_W_DEF,
    parameter int HOLDOFF = HOLDOFF_DEF
) (
    input  logic         Clock,
    input  logic         Reset,
    cyber_press_if.slave bus
);

    localparam int CNT_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    logic [LFSR_W-1:0] rnd_q, rnd_d;
    cp_state_t         ps_q, ps_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              human_press_w;

    // LFSR advances every cycle regardless of freset or enable
    always_comb begin
        rnd_d = {rnd_q[LFSR_W-2:0], ~(rnd_q[LFSR_TAP_HI] ^ rnd_q[LFSR_TAP_LO])};
    end

    // CPU opponent: fire when the threshold beats the random value, then
    // stay quiet for HOLDOFF cycles; freset forces a clean restart
    always_comb begin
        ps_d  = ps_q;
        cnt_d = cnt_q;
        if (bus.freset) begin
            ps_d  = IDLE;
            cnt_d = '0;
        end else begin
            case (ps_q)
                IDLE: begin
                    if (bus.enable && (bus.SW > rnd_q)) begin
                        ps_d = PRESS;
                    end
                end
                PRESS: begin
                    ps_d  = HOLD;
                    cnt_d = CNT_W'(HOLDOFF - 1);
                end
                HOLD: begin
                    if (cnt_q == '0) begin
                        ps_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    ps_d  = IDLE;
                    cnt_d = '0;
                end
            endcase
        end
    end

    // State registers with synchronous full reset (LFSR included)
    always_ff @(posedge Clock) begin
        if (Reset) begin
            rnd_q <= LFSR_W'(LFSR_RESET);
            ps_q  <= IDLE;
            cnt_q <= '0;
        end else begin
            rnd_q <= rnd_d;
            ps_q  <= ps_d;
            cnt_q <= cnt_d;
        end
    end

    key_pulse u_key_pulse (
        .Clock  (Clock),
        .Reset  (Reset),
        .freset (bus.freset),
        .enable (bus.enable),
        .key_n  (bus.key_n),
        .press  (human_press_w)
    );

    // Enable gates only the visible strobe; the FSM still walks into HOLD
    assign bus.cpu_press   = (ps_q == PRESS) && bus.enable;
    assign bus.human_press = human_press_w;
    assign bus.rnd         = rnd_q;

endmodule

// File: tb/tb_cyber_press.sv
// Self-checking bench for cyber_press: directed scenarios plus random traffic.
// Latency: compares outputs 1 time unit after each rising clock edge.
// Backpressure: n/a.
module tb_cyber_press;

    localparam int W  = 10;
    localparam int HO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    cyber_press_if #(.LFSR_W(W)) bus ();

    cyber_press #(.LFSR_W(W), .HOLDOFF(HO)) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [W-1:0] m_rnd   = '0;
    bit           m_fire  = 1'b0; // CPU strobe due this cycle (before enable gating)
    int           m_quiet = 0;    // remaining silent cycles after a strobe
    bit           m_h     = 1'b0;
    bit           hq[$];          // history of sampled key-pressed levels, newest last

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: advance the model from the inputs seen at the edge, then compare
    task automatic step();
        bit pressed;
        bit old_fire;
        logic [W-1:0] old_rnd;
        @(posedge clk);
        pressed  = ~bus.key_n;
        old_rnd  = m_rnd;
        old_fire = m_fire;
        if (rst) begin
            m_rnd   = '0;
            m_fire  = 1'b0;
            m_quiet = 0;
            m_h     = 1'b0;
            hq      = {1'b0, 1'b0, 1'b0};
        end else begin
            // strobe = key seen pressed two samples ago but not three samples ago
            m_h = hq[hq.size()-2] & ~hq[hq.size()-3] & bus.enable & ~bus.freset;
            hq.push_back(pressed);
            void'(hq.pop_front());
            m_rnd = {old_rnd[W-2:0], ~(old_rnd[9] ^ old_rnd[6])};
            if (bus.freset) begin
                m_fire  = 1'b0;
                m_quiet = 0;
            end else if (old_fire) begin
                m_fire  = 1'b0;
                m_quiet = HO;
            end else if (m_quiet > 0) begin
                m_quiet = m_quiet - 1;
            end else begin
                m_fire = bus.enable && (int'(bus.SW) > int'(old_rnd));
            end
        end
        #1;
        chk("rnd", 32'(bus.rnd), 32'(m_rnd));
        chk("cpu_press", 32'(bus.cpu_press), 32'(m_fire & bus.enable));
        chk("human_press", 32'(bus.human_press), 32'(m_h));
    endtask

    logic [W-1:0] lfsr_exp [4];
    int  n_cpu, n_hum, h_first, h_second, found, last_cpu;
    bit  early_zero, saw_3ff;

    initial begin
        lfsr_exp[0] = 10'h001;
        lfsr_exp[1] = 10'h003;
        lfsr_exp[2] = 10'h007;
        lfsr_exp[3] = 10'h00F;
        bus.freset = 1'b0;
        bus.enable = 1'b1;
        bus.key_n  = 1'b1;
        bus.SW     = '0;
        hq         = {1'b0, 1'b0, 1'b0};

        // Reset, then LFSR sequence and full period with SW=0
        rst = 1'b1;
        step();
        step();
        chk("reset_rnd", 32'(bus.rnd), 32'h0);
        chk("reset_cpu", 32'(bus.cpu_press), 32'h0);
        chk("reset_human", 32'(bus.human_press), 32'h0);
        rst = 1'b0;
        n_cpu = 0;
        n_hum = 0;
        early_zero = 1'b0;
        saw_3ff = 1'b0;
        for (int k = 1; k <= 2046; k++) begin
            step();
            if (k <= 4) chk("lfsr_seq", 32'(bus.rnd), 32'(lfsr_exp[k-1]));
            if (k < 1023 && bus.rnd == '0) early_zero = 1'b1;
            if (bus.rnd == 10'h3FF) saw_3ff = 1'b1;
            if (k == 1023) chk("lfsr_period", 32'(bus.rnd), 32'h0);
            n_cpu += int'(bus.cpu_press);
            n_hum += int'(bus.human_press);
        end
        chk("lfsr_no_early_repeat", 32'(early_zero), 32'h0);
        chk("lfsr_never_3ff", 32'(saw_3ff), 32'h0);
        chk("sw0_no_cpu", 32'(n_cpu), 32'h0);
        chk("sw0_no_human", 32'(n_hum), 32'h0);

        // SW=3FF: first strobe in the 2nd cycle after reset drops, then every 6
        bus.SW = 10'h3FF;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            step();
            chk("cpu_spacing", 32'(bus.cpu_press), 32'((k % 6) == 1));
        end

        // Human key: low 10, high 5, low 1 -> two pulses, none on release
        bus.SW = '0;
        n_hum = 0;
        h_first = -1;
        h_second = -1;
        for (int k = 1; k <= 28; k++) begin
            bus.key_n = !((k <= 10) || (k == 16));
            step();
            if (bus.human_press) begin
                n_hum++;
                if (h_first < 0) h_first = k;
                else if (h_second < 0) h_second = k;
            end
        end
        chk("human_count", 32'(n_hum), 32'd2);
        chk("human_first", 32'(h_first), 32'd3);
        chk("human_second", 32'(h_second), 32'd18);

        // freset during HOLD
        bus.key_n = 1'b1;
        bus.SW = 10'h3FF;
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            step();
            if (bus.cpu_press) found = 1;
        end
        chk("wait_cpu_before_freset", 32'(found), 32'd1);
        step();
        step();
        bus.freset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("cpu_quiet_in_freset", 32'(bus.cpu_press), 32'h0);
        end
        bus.freset = 1'b0;
        step();
        chk("press_after_freset", 32'(bus.cpu_press), 32'h1);

        // enable=0 gates both strobes while rnd advances
        bus.enable = 1'b0;
        n_cpu = 0;
        n_hum = 0;
        for (int k = 0; k < 40; k++) begin
            bus.key_n = 1'($urandom_range(0, 1));
            step();
            n_cpu += int'(bus.cpu_press);
            n_hum += int'(bus.human_press);
        end
        chk("disabled_cpu", 32'(n_cpu), 32'h0);
        chk("disabled_human", 32'(n_hum), 32'h0);
        bus.key_n = 1'b0;
        for (int k = 0; k < 4; k++) step();
        bus.enable = 1'b1;
        n_hum = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            n_hum += int'(bus.human_press);
        end
        chk("held_key_on_enable", 32'(n_hum), 32'h0);

        // Reset arriving during a PRESS cycle, key still held
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            if (bus.cpu_press) found = 1;
            else step();
        end
        chk("wait_cpu_before_reset", 32'(found), 32'd1);
        rst = 1'b1;
        step();
        chk("reset_mid_press_cpu", 32'(bus.cpu_press), 32'h0);
        chk("reset_mid_press_rnd", 32'(bus.rnd), 32'h0);
        rst = 1'b0;
        step();
        step();
        step();
        chk("sync_cleared_repulse", 32'(bus.human_press), 32'h1);

        // Random traffic against the model
        last_cpu = 0;
        for (int k = 0; k < 1200; k++) begin
            rst        = ($urandom_range(0, 149) == 0);
            bus.freset = ($urandom_range(0, 24) == 0);
            bus.enable = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 3) == 0) bus.key_n = ~bus.key_n;
            if ($urandom_range(0, 49) == 0) bus.SW = W'($urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cyber_press.md
# cyber_press

Press-pulse generator feeding the tug-of-war light chain. It drives the single-cycle L/R "key pressed" strobes that every playfield light consumes. One side is the human player: a raw active-low key is synchronized and edge-detected into one pulse per press. The other side is the computer opponent: an LFSR compared against the difficulty switches fires rate-limited press pulses. Sits between the board keys/switches and the playfield light chain.

## Interface
- LFSR_W, 10, LFSR width; feedback taps fixed for 10 bits (x^10+x^7+1)
- HOLDOFF, 4, cycles the CPU side stays silent after each press (>=1)
- Clock  in  1  system clock; all state updates on posedge
- Reset  in  1  synchronous, active-high; full reset including LFSR
- freset  in  1  synchronous, active-high round reset; clears press logic, LFSR keeps running
- enable  in  1  game active; gates both press outputs
- key_n  in  1  raw human key, active-low, asynchronous to Clock
- SW  in  LFSR_W  CPU difficulty threshold; larger = more frequent presses
- human_press  out  1  one-cycle strobe per human key press
- cpu_press  out  1  one-cycle strobe per CPU press
- rnd  out  LFSR_W  current LFSR value (observability for verification)

## Operation
- LFSR: rnd <= {rnd[LFSR_W-2:0], ~(rnd[9] ^ rnd[6])} every cycle unless Reset. Advances during freset and with enable=0. Reset value 0. Period 1023; value 10'h3FF never occurs.
- CPU FSM, states IDLE, PRESS, HOLD, reset to IDLE.
  - IDLE -> PRESS when enable & ~freset & (SW > rnd), unsigned compare on the current rnd; otherwise stay in IDLE.
  - PRESS -> HOLD unconditionally; the holdoff counter loads HOLDOFF-1.
  - HOLD: counter decrements each cycle; HOLD -> IDLE in the cycle the counter is 0. HOLD lasts exactly HOLDOFF cycles.
  - freset high in any state -> IDLE next cycle, counter cleared.
  - cpu_press = (ps == PRESS). It is gated by enable: enable low in PRESS suppresses the output but the FSM still proceeds to HOLD.
- Human path:
  - Two flops synchronize pressed = ~key_n (reset 0), followed by a prev flop (reset 0).
  - human_press is registered: human_press <= sync & ~prev & enable & ~freset.
  - A held key yields exactly one pulse; releasing the key yields none.
  - prev tracks sync during freset, so a key held across freset produces no pulse when freset drops.
- L/R assignment to these outputs is done at the top level, not here.

## Timing
- Reset values: human_press=0, cpu_press=0, rnd=0, ps=IDLE, counter=0, sync/prev=0.
- Reset has priority over freset; freset has priority over enable.
- CPU latency: SW>rnd true in IDLE at edge E puts cpu_press high for the cycle after E.
- CPU minimum press spacing is HOLDOFF+2 cycles (IDLE 1 + PRESS 1 + HOLD HOLDOFF); this is 6 at default.
- SW=0: never presses. SW=10'h3FF: presses at every opportunity, since rnd never reaches 3FF.
- Human latency: key_n sampled low at edge E0 -> sync at E1 -> human_press high after E2, low after E3. Worst case 3 cycles from pin to strobe.
- Reset asserted mid-PRESS/HOLD: all outputs 0 from the next cycle and the FSM restarts in IDLE.
- Both strobes may be high in the same cycle; no arbitration.

## Structure
- Package cyber_press_pkg:
  - state typedef (IDLE, PRESS, HOLD)
  - LFSR tap indices (9, 6)
  - LFSR_RESET constant (0)
- Sub-module key_pulse: two-flop synchronizer plus registered rising-edge strobe. Ports Clock, Reset, freset, enable, key_n, press. It is reusable for a second human key.
- Top contains the LFSR, comparator, FSM and holdoff counter.

## Test plan
- Reset 2 cycles then release, SW=0, enable=1 -> rnd sequence 000, 001, 003, 007, 00F; no strobes for 2046 cycles; rnd returns to 000 after 1023 steps.
- SW=3FF, enable=1 after reset -> first cpu_press in the 2nd cycle after Reset drops, then pulses exactly every 6 cycles, each 1 cycle wide.
- key_n low for 10 cycles, high 5, low 1 -> two human_press pulses. Each appears 3 edges after the key_n fall and is 1 cycle wide; none on release.
- SW=3FF, freset pulsed during HOLD for 3 cycles -> FSM IDLE the next cycle; no cpu_press while freset is high; first press 2 cycles after freset drops; rnd unaffected by freset.
- enable=0, SW=3FF, key_n toggling -> both strobes stay 0 while rnd keeps advancing. Raise enable while key_n is held low -> no human pulse until a new press.
- Reset asserted in the same cycle as a PRESS -> cpu_press 0 next cycle, rnd=000, sync flops cleared.
